// File: rtl/redun_mont_sched_pkg.sv
// Shared types for the redun_mont iteration scheduler: operand format,
// modulus used by the multiplier, and the scheduler state encoding.
package redun_mont_sched_pkg;

    localparam int NUM_WRDS = 4;
    localparam int WRD_BITS = 16;
    localparam int VAL_BITS = NUM_WRDS * WRD_BITS;

    // Modulus the downstream redun_mont instance is built for.
    localparam logic [VAL_BITS-1:0] MODULUS = 64'd1000003;

    // Operand in redun_mont's word-split form.
    typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] redun0_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN,
        ERR
    } sched_state_t;

endpackage

// File: rtl/redun_mont_sched_if.sv
// Bundle of the host-side job/result handshake and the redun_mont request/
// response pair. slave is the scheduler's view, master is the surrounding
// host plus multiplier.
interface redun_mont_sched_if #(
    parameter int ITER_BITS = 64
);
    import redun_mont_sched_pkg::*;

    // host job request
    logic                 i_start;
    redun0_t              i_sq;
    logic [ITER_BITS-1:0] i_iter;
    logic                 i_abort;
    // host result side
    logic                 o_busy;
    redun0_t              o_sq;
    logic                 o_val;
    logic                 i_rdy;
    logic [ITER_BITS-1:0] o_iter_cnt;
    logic                 o_overflow;
    logic                 o_error;
    // redun_mont side
    redun0_t              o_mont_sq;
    logic                 o_mont_val;
    redun0_t              i_mont_mul;
    logic                 i_mont_val;
    logic                 i_mont_overflow;

    modport slave (
        input  i_start, i_sq, i_iter, i_abort, i_rdy,
        input  i_mont_mul, i_mont_val, i_mont_overflow,
        output o_busy, o_sq, o_val, o_iter_cnt, o_overflow, o_error,
        output o_mont_sq, o_mont_val
    );

    modport master (
        output i_start, i_sq, i_iter, i_abort, i_rdy,
        output i_mont_mul, i_mont_val, i_mont_overflow,
        input  o_busy, o_sq, o_val, o_iter_cnt, o_overflow, o_error,
        input  o_mont_sq, o_mont_val
    );

endinterface

// File: rtl/redun_mont_sched.sv
// Iteration controller for redun_mont: runs T dependent modular squarings,
// one in flight at a time, feeding each product back as the next operand.
// Includes a response watchdog, abort with drain of the in-flight result,
// and sticky overflow/error flags. All outputs are registered.
module redun_mont_sched
    import redun_mont_sched_pkg::*;
#(
    parameter int ITER_BITS = 64,
    parameter int WDOG_CYC  = 256
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    redun_mont_sched_if.slave  bus
);

    localparam int WD_BITS = $clog2(WDOG_CYC + 1);

    sched_state_t         state, state_nxt;
    redun0_t              val_q;
    logic [ITER_BITS-1:0] iter_q;
    logic [WD_BITS-1:0]   wdog;
    logic [ITER_BITS-1:0] cnt_inc;
    logic                 last;
    logic                 wd_exp;

    // cnt never exceeds T-1 while a squaring is pending, so the increment
    // cannot wrap even for T at its maximum.
    assign cnt_inc = bus.o_iter_cnt + ITER_BITS'(1);
    assign last    = (cnt_inc == iter_q);
    // >= rather than == so an abort landing on the expiry cycle still ends
    // the drain instead of waiting for the counter to wrap.
    assign wd_exp  = (wdog >= WD_BITS'(WDOG_CYC - 1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state selection; abort outranks everything, a response outranks
    // a same-cycle watchdog expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.i_start) state_nxt = (bus.i_iter == '0) ? DONE : ISSUE;
            ISSUE: state_nxt = bus.i_abort ? IDLE : WAIT;
            WAIT: begin
                if (bus.i_abort)         state_nxt = bus.i_mont_val ? IDLE : DRAIN;
                else if (bus.i_mont_val) state_nxt = last ? DONE : ISSUE;
                else if (wd_exp)         state_nxt = ERR;
            end
            DONE:  if (bus.i_abort || (bus.o_val && bus.i_rdy)) state_nxt = IDLE;
            DRAIN: if (bus.i_mont_val || wd_exp) state_nxt = IDLE;
            ERR:   if (bus.i_abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, watchdog and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val_q          <= '0;
            iter_q         <= '0;
            wdog           <= '0;
            bus.o_busy     <= 1'b0;
            bus.o_sq       <= '0;
            bus.o_val      <= 1'b0;
            bus.o_iter_cnt <= '0;
            bus.o_overflow <= 1'b0;
            bus.o_error    <= 1'b0;
            bus.o_mont_sq  <= '0;
            bus.o_mont_val <= 1'b0;
        end else begin
            bus.o_busy     <= (state_nxt != IDLE);
            bus.o_mont_val <= (state == ISSUE) && !bus.i_abort;
            // o_val rises the cycle after DONE is entered and drops on the
            // handshake edge itself.
            bus.o_val      <= (state == DONE) && (state_nxt == DONE);
            if (state == DONE) bus.o_sq <= val_q;

            case (state)
                IDLE: if (bus.i_start) begin
                    val_q          <= bus.i_sq;
                    iter_q         <= bus.i_iter;
                    bus.o_iter_cnt <= '0;
                    bus.o_overflow <= 1'b0;
                    bus.o_error    <= 1'b0;
                end
                ISSUE: begin
                    bus.o_mont_sq <= val_q;
                    wdog          <= '0;
                end
                WAIT: begin
                    wdog <= wdog + WD_BITS'(1);
                    if (bus.i_mont_val) begin
                        bus.o_overflow <= bus.o_overflow | bus.i_mont_overflow;
                        if (!bus.i_abort) begin
                            val_q          <= bus.i_mont_mul;
                            bus.o_iter_cnt <= cnt_inc;
                        end
                    end else if (!bus.i_abort && wd_exp) begin
                        bus.o_error <= 1'b1;
                    end
                end
                DRAIN: wdog <= wdog + WD_BITS'(1);
                default: ;
            endcase

            // A response nobody asked for is reported even on a start edge.
            if (bus.i_mont_val && (state != WAIT) && (state != DRAIN))
                bus.o_error <= 1'b1;
        end
    end

endmodule
